mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/mux2x1.sv | 17 +
 rtl/mux_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter.
//   state_t      : FSM state encoding (IDLE / GNT_A / GNT_B)
//   SEL_A, SEL_B : shared-mux select codes, also used as the last-grant marker
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux2x1.sv
// Plain combinational 2:1 multiplexer.
//   sel_i : 0 selects a_i, 1 selects b_i
//   a_i   : input 0 data
//   b_i   : input 1 data
//   y_o   : selected data
module mux2x1 #(
    parameter int WIDTH = 4
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule : mux2x1

// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared, registered output mux.
// Grants alternate fairly on simultaneous requests, a holder is
// pre-empted after MAX_HOLD consecutive cycles only if the other side waits.
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   req_a/b   : level-sensitive requests
//   data_a/b  : requester data
//   gnt_a/b   : Moore grants (never both high)
//   sel       : shared-mux select (0 = A, 1 = B), held while idle
//   out_data  : registered mux output
//   out_valid : out_data carries a granted transfer
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             sel_q, sel_d;
    logic             gnt_a_q, gnt_b_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] mux_y;

    // Next-state logic. Entering a grant state always records the side,
    // clears the hold counter and moves the select with it.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        unique case (state_q)
            IDLE: begin
                if (req_a && (!req_b || last_gnt_q == SEL_B)) begin
                    state_d = GNT_A; last_gnt_d = SEL_A; hold_cnt_d = '0; sel_d = SEL_A;
                end else if (req_b) begin
                    state_d = GNT_B; last_gnt_d = SEL_B; hold_cnt_d = '0; sel_d = SEL_B;
                end
            end
            GNT_A: begin
                if (!req_a || (hold_cnt_q == HOLD_LAST && req_b)) begin
                    // Hand over directly when B waits; no idle bubble.
                    if (req_b) begin
                        state_d = GNT_B; last_gnt_d = SEL_B; hold_cnt_d = '0; sel_d = SEL_B;
                    end else begin
                        state_d = IDLE; hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;   // nobody waiting: keep the grant, restart the window
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            GNT_B: begin
                if (!req_b || (hold_cnt_q == HOLD_LAST && req_a)) begin
                    if (req_a) begin
                        state_d = GNT_A; last_gnt_d = SEL_A; hold_cnt_d = '0; sel_d = SEL_A;
                    end else begin
                        state_d = IDLE; hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE; hold_cnt_d = '0;
            end
        endcase
    end

    mux2x1 #(.WIDTH(WIDTH)) u_mux (
        .sel_i (sel_q),
        .a_i   (data_a),
        .b_i   (data_b),
        .y_o   (mux_y)
    );

    // Grants are registered alongside the state so they stay pure Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= SEL_B;   // A wins the first simultaneous request
            hold_cnt_q  <= '0;
            sel_q       <= SEL_A;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            hold_cnt_q  <= hold_cnt_d;
            sel_q       <= sel_d;
            gnt_a_q     <= (state_d == GNT_A);
            gnt_b_q     <= (state_d == GNT_B);
            out_data_q  <= mux_y;
            out_valid_q <= (gnt_a_q & req_a) | (gnt_b_q & req_b);
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [3:0] data_a, data_b;
    logic       gnt_a, gnt_b, sel, out_valid;
    logic [3:0] out_data;

    logic       r1a, r1b;
    logic       g1a, g1b, s1, v1;
    logic [3:0] o1;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_e;
    logic       prev_ga = 1'b0;
    logic       prev_gb = 1'b0;

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .sel(sel), .out_data(out_data), .out_valid(out_valid)
    );

    mux_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req_a(r1a), .req_b(r1b),
        .data_a(data_a), .data_b(data_b), .gnt_a(g1a), .gnt_b(g1b),
        .sel(s1), .out_data(o1), .out_valid(v1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus with hand-computed grant/select after the edge.
    // A transfer is expected whenever the side granted before the edge still requests.
    task automatic cyc(input logic ra, input logic rb, input logic [3:0] da, input logic [3:0] db,
                       input logic ega, input logic egb, input logic esel);
        req_a = ra; req_b = rb; data_a = da; data_b = db;
        if (prev_ga && ra) exp_q.push_back(da);
        else if (prev_gb && rb) exp_q.push_back(db);
        @(posedge clk); #1;
        chk("gnt_sel", {5'd0, gnt_a, gnt_b, sel}, {5'd0, ega, egb, esel});
        $display("cyc t=%0t req=%b%b gnt=%b%b sel=%b valid=%b data=%h",
                 $time, ra, rb, gnt_a, gnt_b, sel, out_valid, out_data);
        prev_ga = ega; prev_gb = egb;
    endtask

    // Scoreboard monitor: every valid output must match the oldest expectation.
    always @(posedge clk) begin
        #2;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: got data %h want no transfer at %0t", out_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", {4'h0, out_data}, {4'h0, mon_e});
            end
        end
    end

    initial begin
        reset = 1'b1; req_a = 0; req_b = 0; data_a = 0; data_b = 0; r1a = 0; r1b = 0;
        #1;
        chk("reset_out", {3'd0, gnt_a, gnt_b, sel, out_valid, 1'b0}, 8'h00);
        chk("reset_data", {4'h0, out_data}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;

        // Both requesting: A first, then A x4 / B x4 / A x4.
        for (int i = 0; i < 12; i++) begin
            logic a;
            a = (i < 4) || (i >= 8);
            cyc(1, 1, 4'h3, 4'hC, a, !a, !a);
        end
        // A drops while B waits: direct hand-over, then B data only.
        cyc(0, 1, 4'h3, 4'hC, 0, 1, 1);
        cyc(0, 1, 4'hF, 4'hC, 0, 1, 1);
        cyc(0, 1, 4'h7, 4'h5, 0, 1, 1);
        cyc(0, 0, 4'h7, 4'h5, 0, 0, 1);   // idle keeps select
        cyc(1, 0, 4'h2, 4'h9, 1, 0, 0);
        // A alone past several hold windows.
        for (int i = 0; i < 10; i++) cyc(1, 0, 4'(i), 4'hF, 1, 0, 0);
        cyc(0, 0, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 1, 4'h6, 4'hA, 0, 1, 1);   // last grant was A, so B wins
        cyc(0, 1, 4'h6, 4'hA, 0, 1, 1);

        // Asynchronous reset in the middle of GNT_B.
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out", {3'd0, gnt_a, gnt_b, sel, out_valid, 1'b0}, 8'h00);
        chk("async_rst_data", {4'h0, out_data}, 8'h00);
        req_a = 0; req_b = 0; prev_ga = 0; prev_gb = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1, 1, 4'h3, 4'hC, 1, 0, 0);
        cyc(1, 1, 4'h3, 4'hC, 1, 0, 0);
        cyc(0, 0, 4'h3, 4'hC, 0, 0, 0);
        cyc(0, 0, 4'h3, 4'hC, 0, 0, 0);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        // MAX_HOLD = 1: grants alternate every cycle.
        r1a = 1; r1b = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("alt_hold1", {6'd0, g1a, g1b}, (i % 2 == 0) ? 8'h02 : 8'h01);
            $display("alt t=%0t gnt=%b%b", $time, g1a, g1b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_arbiter
